pirdsp_simd_mac_pipelined: RTL
==============================

PIRDSP_SIMD_MAC_PIPELINED -- requirements
Module: pirdsp_simd_mac_pipelined

Interface
REQ-001 SHALL provide parameter A_WIDTH, default 27, meaning the A operand width; A_WIDTH >= B_WIDTH.
REQ-002 SHALL provide parameter B_WIDTH, default 18, meaning the B operand width; B_WIDTH >= 9.
REQ-003 SHALL provide parameter ACC_WIDTH, default 48, meaning the accumulator and output width; ACC_WIDTH >= A_WIDTH+B_WIDTH+2.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk, input, 1, clock; all state updates on its rising edge.
REQ-005 reset, input, 1, synchronous active-high reset.
REQ-006 a, input, A_WIDTH, multiplicand, or packed lanes.
REQ-007 b, input, B_WIDTH, multiplier, or packed lanes.
REQ-008 a_sign / b_sign, input, 1 each, 1 = operand(s) two's-complement.
REQ-009 mode, input, 2: 00 full product; 01 sum of 9x9 lanes; 10 sum of 4x4 lanes; 11 behaves as 00.
REQ-010 acc_en, input, 1, 1 = add to accumulator, 0 = load accumulator.
REQ-011 in_valid input 1 / in_ready output 1, input handshake.
REQ-012 out_valid output 1 / out_ready input 1, output handshake.
REQ-013 out_data, output, ACC_WIDTH, accumulator value.
REQ-014 acc_ovf, output, 1, sticky signed-overflow flag.

Function
REQ-015 Transfer occurs when in_valid&in_ready; a, b, signs, mode, acc_en SHALL be captured together.
REQ-016 Pipeline SHALL be 3 stages: S1 operand register, S2 product/lane-sum register, S3 accumulator/output register, each with a valid bit.
REQ-017 advance = ~out_valid | out_ready; all stages SHALL shift only when advance=1; in_ready = advance.
REQ-018 Transfer in cycle t with no stall SHALL give out_valid=1 in cycle t+3; stalls add cycles 1:1.
REQ-019 Mode 00: product = a*b, with each operand sign- or zero-extended per its sign bit.
REQ-020 Mode 01: L9 = floor(B_WIDTH/9) lanes; lane k uses a[9k+8:9k] and b[9k+8:9k]; sum = sum of lane products; upper a bits are ignored.
REQ-021 Mode 10: L4 = floor(B_WIDTH/4) lanes of 4 bits; lane rules as REQ-020.
REQ-022 Lane signedness SHALL follow a_sign/b_sign per lane; the sum SHALL be exact and extended to ACC_WIDTH.
REQ-023 When S3 loads a valid entry: acc_en=0 -> acc <= sum and acc_ovf <= 0; acc_en=1 -> acc <= acc + sum, wrapping modulo 2^ACC_WIDTH.
REQ-024 acc_ovf SHALL set when a REQ-023 add overflows as a signed ACC_WIDTH add, and hold until the next acc_en=0 load or reset.
REQ-025 A bubble (S2 invalid) SHALL leave acc and acc_ovf unchanged; out_valid SHALL drop after the output handshake if no new entry loads.
REQ-026 out_data SHALL equal acc and hold stable while out_valid&~out_ready.
REQ-027 Order SHALL be preserved; no entry lost or duplicated under any in_valid/out_ready pattern.
REQ-028 mode and sign bits SHALL apply per entry; back-to-back mode changes SHALL be legal.

Reset
REQ-029 Reset SHALL clear all valid bits, acc, out_data, and acc_ovf to 0; out_valid=0 in the cycle after reset.
REQ-030 Reset mid-operation SHALL discard in-flight entries; in_ready=1 in the cycle after reset is released.
REQ-031 Reset SHALL take priority over a simultaneous transfer.

Verification
REQ-032 Mode 00, signed, a=-3, b=5, acc_en=0 -> out_data=48'hFFFF_FFFF_FFF1 in cycle t+3.
REQ-033 Mode 01, unsigned, a lanes {20,10}, b lanes {4,3}, acc_en=0 -> out_data=110.
REQ-034 Mode 10, signed, all 4 lanes a=4'hF, b=4'h2 -> out_data=-8 (48'hFFFF_FFFF_FFF8).
REQ-035 Back-to-back mode 00 unsigned 100*2 with acc_en 0,1,1 -> outputs 200, 400, 600 on consecutive cycles.
REQ-036 out_ready=0 for 6 cycles while 5 entries are offered -> in_ready=0 once 3 are held; all 5 emerge in order after release.
REQ-037 Signed (-2^26)*(-2^17) = 2^43: load, then 15 accumulates -> 16th output is -2^47 with acc_ovf=1; next acc_en=0 clears acc_ovf.

Source files
------------

// File: rtl/pirdsp_simd_mac_pipelined.sv
// ---------------------------------------------------------------------------
// pirdsp_simd_mac_pipelined
//
// Three-stage SIMD multiply-accumulate unit. Each accepted entry is either a
// full a*b product, the sum of 9x9 lane products or the sum of 4x4 lane
// products. That value is then loaded into, or added to, a wrapping
// accumulator. The accumulator has a sticky signed-overflow flag.
//
// Ports
//   clk, reset            : clock and synchronous active-high reset
//   a [A_WIDTH-1:0]       : multiplicand (or packed lanes)
//   b [B_WIDTH-1:0]       : multiplier (or packed lanes)
//   a_sign, b_sign        : 1 = operand lanes are two's complement
//   mode [1:0]            : 00/11 full product, 01 9-bit lanes, 10 4-bit lanes
//   acc_en                : 1 = accumulate, 0 = load accumulator
//   in_valid / in_ready   : input handshake
//   out_valid / out_ready : output handshake
//   out_data [ACC_WIDTH]  : accumulator value
//   acc_ovf               : sticky signed-overflow flag
// ---------------------------------------------------------------------------
module pirdsp_simd_mac_pipelined #(
    parameter int A_WIDTH   = 27,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic [1:0]           mode,
    input  logic                 acc_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 acc_ovf
);

    localparam int L9 = B_WIDTH / 9;
    localparam int L4 = B_WIDTH / 4;

    // The whole pipeline moves as one unit. It only freezes when the output
    // holds a result that nobody has taken yet.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Stage 1: operand register
    logic                 s1_valid;
    logic [A_WIDTH-1:0]   s1_a;
    logic [B_WIDTH-1:0]   s1_b;
    logic                 s1_a_sign;
    logic                 s1_b_sign;
    logic [1:0]           s1_mode;
    logic                 s1_acc_en;

    // Stage 2: product / lane-sum register
    logic                 s2_valid;
    logic [ACC_WIDTH-1:0] s2_sum;
    logic                 s2_acc_en;

    // Stage 3: accumulator
    logic [ACC_WIDTH-1:0] acc;

    // The helper functions below sign- or zero-extend an operand (or lane) to
    // the accumulator width. Multiplying the extended values modulo
    // 2^ACC_WIDTH gives the exact product, because ACC_WIDTH leaves headroom
    // above A_WIDTH+B_WIDTH.
    function automatic logic [ACC_WIDTH-1:0] ext_a(input logic [A_WIDTH-1:0] v, input logic s);
        return {{(ACC_WIDTH-A_WIDTH){s & v[A_WIDTH-1]}}, v};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] ext_b(input logic [B_WIDTH-1:0] v, input logic s);
        return {{(ACC_WIDTH-B_WIDTH){s & v[B_WIDTH-1]}}, v};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] ext9(input logic [8:0] v, input logic s);
        return {{(ACC_WIDTH-9){s & v[8]}}, v};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] ext4(input logic [3:0] v, input logic s);
        return {{(ACC_WIDTH-4){s & v[3]}}, v};
    endfunction

    // This block computes the product or lane sum for the entry held in
    // stage 1. Lanes come from the low bits of a and b. Any a bits above the
    // last lane do not contribute.
    logic [ACC_WIDTH-1:0] full_prod;
    logic [ACC_WIDTH-1:0] lane9_sum;
    logic [ACC_WIDTH-1:0] lane4_sum;
    logic [ACC_WIDTH-1:0] s1_sum;

    always_comb begin
        full_prod = ext_a(s1_a, s1_a_sign) * ext_b(s1_b, s1_b_sign);
        lane9_sum = '0;
        for (int k = 0; k < L9; k++) begin
            lane9_sum = lane9_sum + ext9(s1_a[9*k +: 9], s1_a_sign) * ext9(s1_b[9*k +: 9], s1_b_sign);
        end
        lane4_sum = '0;
        for (int k = 0; k < L4; k++) begin
            lane4_sum = lane4_sum + ext4(s1_a[4*k +: 4], s1_a_sign) * ext4(s1_b[4*k +: 4], s1_b_sign);
        end
        case (s1_mode)
            2'b01:   s1_sum = lane9_sum;
            2'b10:   s1_sum = lane4_sum;
            default: s1_sum = full_prod;
        endcase
    end

    // This block computes the accumulate path. Overflow means both addends
    // have the same sign and the wrapped result has the other sign.
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 add_ovf;

    always_comb begin
        acc_next = acc + s2_sum;
        add_ovf  = (acc[ACC_WIDTH-1] == s2_sum[ACC_WIDTH-1]) &&
                   (acc_next[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    end

    // Stage 1 captures all fields of an entry together. A cycle with no
    // transfer while the pipeline advances leaves a bubble behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_a_sign <= 1'b0;
            s1_b_sign <= 1'b0;
            s1_mode   <= 2'b00;
            s1_acc_en <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a      <= a;
                s1_b      <= b;
                s1_a_sign <= a_sign;
                s1_b_sign <= b_sign;
                s1_mode   <= mode;
                s1_acc_en <= acc_en;
            end
        end
    end

    // Stage 2 registers the product or lane sum, plus the accumulate
    // control that travels with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_sum    <= '0;
            s2_acc_en <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum    <= s1_sum;
                s2_acc_en <= s1_acc_en;
            end
        end
    end

    // Stage 3 is the accumulator. A bubble drops out_valid but leaves acc
    // and acc_ovf untouched. A load clears the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                if (s2_acc_en) begin
                    acc     <= acc_next;
                    acc_ovf <= acc_ovf | add_ovf;
                end else begin
                    acc     <= s2_sum;
                    acc_ovf <= 1'b0;
                end
            end
        end
    end

    assign out_data = acc;

endmodule
